// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

    // Receive FSM states; one bit period per sampled state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_PUSH,
        ST_WAIT_IDLE
    } rx_state_t;

    // parity_mode bit positions.
    localparam int PAR_EN_BIT  = 1;
    localparam int PAR_ODD_BIT = 0;

    // parity_error_mode encodings (2 and 3 both store the word with its flag).
    localparam logic [1:0] PERR_IGNORE = 2'd0;
    localparam logic [1:0] PERR_DROP   = 2'd1;
    localparam logic [1:0] PERR_STORE  = 2'd2;

    // FIFO entry layout: {break, parity_err, frame_err, data[8:0]}.
    localparam int ENTRY_W = 12;

    typedef struct packed {
        logic       brk;
        logic       parity_err;
        logic       frame_err;
        logic [8:0] data;
    } rx_entry_t;

    // Requested word length folded into the supported 5..9 range.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
        if (n < 4'd5) begin
            return 4'd5;
        end else if (n > 4'd9) begin
            return 4'd9;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on dout whenever
// empty=0; a push while full is accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; on push-while-full-with-pop the slot being vacated is reused.
    // NOTE: the storage array is deliberately not reset; occupancy tracking
    // guarantees no stale entry is ever presented as valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronizer, start-aligned tick
// generator, 3-sample majority vote per bit, runtime frame format, and a
// show-ahead FIFO holding each word with its framing/parity/break flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_DIV_WIDTH = 16,
    parameter int OS_RATE       = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CLK_DIV_WIDTH-1:0] clk_div,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               parity_mode,
    input  logic [1:0]               parity_error_mode,
    input  logic                     stop_bits,
    input  logic                     rx,
    input  logic                     rd,
    output logic [8:0]               datao,
    output logic                     dvalid,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     break_det,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     busy
);

    localparam int OS_W = $clog2(OS_RATE);
    localparam logic [OS_W-1:0] SMP0    = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0] SMP1    = OS_W'(OS_RATE / 2);
    localparam logic [OS_W-1:0] SMP2    = OS_W'(OS_RATE / 2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);

    // Synchronizer and edge detect.
    logic rx_m;
    logic rx_s;
    logic rx_s_d;
    logic start_det;

    // Tick generation and sampling.
    logic [CLK_DIV_WIDTH-1:0] div_cnt;
    logic [OS_W-1:0]          os_cnt;
    logic                     tick;
    logic                     smp0;
    logic                     smp1;
    logic                     sampling;
    logic                     bit_done;
    logic                     bit_val;

    // Frame state and per-frame configuration captured at start detect.
    rx_state_t  state;
    logic [3:0] cfg_bits;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic [1:0] cfg_perr_mode;
    logic       cfg_stop2;
    logic [8:0] data_sr;
    logic [3:0] bit_idx;
    logic       par_rx;
    logic       all_zero;
    logic       frame_err_r;
    logic       brk_r;

    // Push path.
    logic       par_calc;
    logic       perr;
    logic       push_req;
    logic       ovf_set;
    rx_entry_t  push_entry;
    rx_entry_t  head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    // Two-stage synchronizer plus one delay stage for falling-edge detect;
    // flops reset to the idle-high line level so reset never fakes a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            rx_s_d <= 1'b1;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            rx_s_d <= rx_s;
        end
    end

    assign start_det = (state == ST_IDLE) && rx_s_d && !rx_s;
    assign tick      = (div_cnt == clk_div);

    // Oversample tick generator; restarts on start detect so bit phase
    // is referenced to the falling edge of the start bit.
    always_ff @(posedge clk) begin
        if (reset || start_det) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end else begin
            div_cnt <= div_cnt + CLK_DIV_WIDTH'(1);
        end
    end

    // Capture the first two of the three mid-bit samples; the third is live rx_s.
    always_ff @(posedge clk) begin
        if (reset) begin
            smp0 <= 1'b0;
            smp1 <= 1'b0;
        end else if (tick) begin
            if (os_cnt == SMP0) begin
                smp0 <= rx_s;
            end
            if (os_cnt == SMP1) begin
                smp1 <= rx_s;
            end
        end
    end

    assign sampling = (state == ST_START) || (state == ST_DATA) || (state == ST_PARITY)
                   || (state == ST_STOP1) || (state == ST_STOP2);
    assign bit_done = sampling && tick && (os_cnt == SMP2);
    assign bit_val  = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);

    // Receive FSM: walks the frame one majority decision per bit and
    // accumulates data and flags for the push cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cfg_bits      <= 4'd5;
            cfg_par_en    <= 1'b0;
            cfg_par_odd   <= 1'b0;
            cfg_perr_mode <= PERR_IGNORE;
            cfg_stop2     <= 1'b0;
            data_sr       <= '0;
            bit_idx       <= '0;
            par_rx        <= 1'b0;
            all_zero      <= 1'b1;
            frame_err_r   <= 1'b0;
            brk_r         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        state         <= ST_START;
                        cfg_bits      <= clamp_data_bits(data_bits);
                        cfg_par_en    <= parity_mode[PAR_EN_BIT];
                        cfg_par_odd   <= parity_mode[PAR_ODD_BIT];
                        cfg_perr_mode <= parity_error_mode;
                        cfg_stop2     <= stop_bits;
                        data_sr       <= '0;
                        bit_idx       <= '0;
                        par_rx        <= 1'b0;
                        all_zero      <= 1'b1;
                        frame_err_r   <= 1'b0;
                        brk_r         <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        state <= bit_val ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        data_sr[bit_idx] <= bit_val;
                        all_zero         <= all_zero & ~bit_val;
                        if (bit_idx == cfg_bits - 4'd1) begin
                            state <= cfg_par_en ? ST_PARITY : ST_STOP1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        par_rx   <= bit_val;
                        all_zero <= all_zero & ~bit_val;
                        state    <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (bit_done) begin
                        frame_err_r <= ~bit_val;
                        brk_r       <= all_zero & ~bit_val;
                        state       <= cfg_stop2 ? ST_STOP2 : ST_PUSH;
                    end
                end
                ST_STOP2: begin
                    if (bit_done) begin
                        frame_err_r <= frame_err_r | ~bit_val;
                        state       <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state <= frame_err_r ? ST_WAIT_IDLE : ST_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // Expected parity bit for the received data; upper unused data bits are 0.
    assign par_calc = (^data_sr) ^ cfg_par_odd;
    assign perr     = cfg_par_en && (cfg_perr_mode != PERR_IGNORE) && (par_rx != par_calc);
    assign push_req = (state == ST_PUSH) && !(perr && (cfg_perr_mode == PERR_DROP));
    assign ovf_set  = push_req && fifo_full && !rd;

    // Assemble the FIFO entry for the push cycle.
    // NOTE: every signal driven in always_comb gets a value on every path
    // (here unconditionally) so no latch is inferred.
    always_comb begin
        push_entry            = '0;
        push_entry.brk        = brk_r;
        push_entry.parity_err = perr;
        push_entry.frame_err  = frame_err_r;
        push_entry.data       = data_sr;
    end

    // Sticky overflow; a fresh overflow wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (rd),
        .din   (push_entry),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head fields are gated so outputs read 0 while the FIFO is empty.
    assign head       = fifo_dout;
    assign dvalid     = !fifo_empty;
    assign datao      = dvalid ? head.data : '0;
    assign frame_err  = dvalid && head.frame_err;
    assign parity_err = dvalid && head.parity_err;
    assign break_det  = dvalid && head.brk;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os. A frame-level model predicts the FIFO
// contents from the words sent and the format rules; a compare process checks
// the DUT head against it every cycle, and directed checks pin key values.
module tb_uart_rx_os;

    localparam int OS   = 16;
    localparam int DEPT = 8;

    logic        clk;
    logic        reset;
    logic [15:0] clk_div;
    logic [3:0]  data_bits;
    logic [1:0]  parity_mode;
    logic [1:0]  parity_error_mode;
    logic        stop_bits;
    logic        rx;
    logic        rd;
    logic [8:0]  datao;
    logic        dvalid;
    logic        frame_err;
    logic        parity_err;
    logic        break_det;
    logic        overflow;
    logic        overflow_clr;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic        run_cmp = 1'b0;

    uart_rx_os #(
        .CLK_DIV_WIDTH (16),
        .OS_RATE       (OS),
        .FIFO_DEPTH    (DEPT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_div           (clk_div),
        .data_bits         (data_bits),
        .parity_mode       (parity_mode),
        .parity_error_mode (parity_error_mode),
        .stop_bits         (stop_bits),
        .rx                (rx),
        .rd                (rd),
        .datao             (datao),
        .dvalid            (dvalid),
        .frame_err         (frame_err),
        .parity_err        (parity_err),
        .break_det         (break_det),
        .overflow          (overflow),
        .overflow_clr      (overflow_clr),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bit a transmitter would send: even makes the total count even.
    function automatic logic sent_parity(input logic [8:0] d, input int nb, input logic odd);
        int ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(d[i]);
        return logic'(ones % 2) ^ odd;
    endfunction

    // Entry the receiver must store for a well-framed word.
    function automatic logic [11:0] expected_entry(input logic [8:0] d, input int nb,
                                                   input logic pen, input logic [1:0] pem,
                                                   input logic flip);
        logic [8:0] m = '0;
        for (int i = 0; i < nb; i++) m[i] = d[i];
        return {1'b0, pen && (pem != 2'd0) && flip, 1'b0, m};
    endfunction

    // Every cycle: empty model means no valid head; otherwise head must match.
    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            if (exp_q.size() == 0) begin
                check("dvalid_when_empty", {31'd0, dvalid}, 32'd0);
            end else if (dvalid) begin
                check("head_entry", {20'd0, break_det, parity_err, frame_err, datao},
                      {20'd0, exp_q[0]});
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b1;
        end
    endtask

    // Send one frame with the current configuration; optionally invert the line
    // for cycles glo..ghi of line bit gbit (bit 0 = start bit).
    task automatic frame(input logic [8:0] d, input logic flip, input int gbit,
                         input int glo, input int ghi);
        logic q[$];
        int   nb  = int'(data_bits);
        int   bcl = (int'(clk_div) + 1) * OS;
        logic pen = parity_mode[1];
        logic [11:0] e;
        e = expected_entry(d, nb, pen, parity_error_mode, flip);
        if (!(pen && parity_error_mode == 2'd1 && flip)) begin
            if (exp_q.size() < DEPT) exp_q.push_back(e);
            else exp_ovf = 1'b1;
        end
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(d[i]);
        if (pen) q.push_back(sent_parity(d, nb, parity_mode[0]) ^ flip);
        q.push_back(1'b1);
        if (stop_bits) q.push_back(1'b1);
        for (int b = 0; b < q.size(); b++) begin
            for (int j = 0; j < bcl; j++) begin
                @(posedge clk);
                #1 rx = (b == gbit && j >= glo && j <= ghi) ? ~q[b] : q[b];
            end
        end
    endtask

    task automatic do_pop();
        @(negedge clk);
        check("pop_dvalid", {31'd0, dvalid}, 32'd1);
        rd = 1'b1;
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        #1 rd = 1'b0;
    endtask

    initial begin
        rx = 1'b1; rd = 1'b0; reset = 1'b1; overflow_clr = 1'b0;
        clk_div = 16'd3; data_bits = 4'd8; parity_mode = 2'b00;
        parity_error_mode = 2'd0; stop_bits = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_datao", {23'd0, datao}, 32'd0);
        check("rst_dvalid", {31'd0, dvalid}, 32'd0);
        check("rst_flags", {29'd0, break_det, parity_err, frame_err}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        run_cmp = 1'b1;

        // 8N1, 0xA5
        frame(9'h0A5, 1'b0, -1, 0, 0);
        idle(64);
        @(negedge clk);
        check("a5_datao", {23'd0, datao}, 32'h0A5);
        check("a5_dvalid", {31'd0, dvalid}, 32'd1);
        check("a5_flags", {29'd0, break_det, parity_err, frame_err}, 32'd0);
        do_pop();
        @(negedge clk);
        check("a5_popped", {31'd0, dvalid}, 32'd0);

        // 9 data bits, odd parity, two stop bits
        data_bits = 4'd9; parity_mode = 2'b11; stop_bits = 1'b1; parity_error_mode = 2'd1;
        check("pin_parity", {31'd0, sent_parity(9'h1C3, 9, 1'b1)}, 32'd0);
        check("pin_entry", {20'd0, expected_entry(9'h1C3, 9, 1'b1, 2'd2, 1'b1)}, 32'h5C3);
        frame(9'h1C3, 1'b0, -1, 0, 0);
        idle(64);
        @(negedge clk);
        check("9o2_datao", {23'd0, datao}, 32'h1C3);
        check("9o2_perr", {31'd0, parity_err}, 32'd0);
        do_pop();
        frame(9'h1C3, 1'b1, -1, 0, 0);
        idle(64);
        @(negedge clk);
        check("mode1_dropped", {31'd0, dvalid}, 32'd0);
        check("mode1_no_ovf", {31'd0, overflow}, 32'd0);
        parity_error_mode = 2'd2;
        frame(9'h1C3, 1'b1, -1, 0, 0);
        idle(64);
        @(negedge clk);
        check("mode2_datao", {23'd0, datao}, 32'h1C3);
        check("mode2_perr", {31'd0, parity_err}, 32'd1);
        check("mode2_ferr", {31'd0, frame_err}, 32'd0);
        do_pop();

        // False start: 200-clk glitch at 800 clk/bit
        data_bits = 4'd8; parity_mode = 2'b00; stop_bits = 1'b0; parity_error_mode = 2'd0;
        clk_div = 16'd49;
        idle(20);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
        @(negedge clk);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        idle(1200);
        @(negedge clk);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_no_push", {31'd0, dvalid}, 32'd0);
        clk_div = 16'd3;
        idle(64);

        // Break: line low for 20 bit times
        exp_q.push_back(12'hA00);
        for (int i = 0; i < 20 * 64; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
        @(negedge clk);
        check("brk_wait_idle", {31'd0, busy}, 32'd1);
        check("brk_datao", {23'd0, datao}, 32'd0);
        check("brk_flags", {29'd0, break_det, parity_err, frame_err}, 32'b101);
        idle(128);
        @(negedge clk);
        check("brk_released", {31'd0, busy}, 32'd0);
        do_pop();
        @(negedge clk);
        check("brk_single", {31'd0, dvalid}, 32'd0);

        // Overflow: nine words, no reads
        for (int w = 0; w < 9; w++) begin
            frame(9'((w * 17 + 3) & 8'hFF), 1'b0, -1, 0, 0);
            idle(16);
        end
        idle(64);
        @(negedge clk);
        check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
        check("ovf_head", {23'd0, datao}, 32'h003);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        for (int w = 0; w < 8; w++) do_pop();
        @(negedge clk);
        check("ovf_ninth_lost", {31'd0, dvalid}, 32'd0);

        // Middle-sample glitch on data bit 3 (line bit 4) of 0x00
        frame(9'h000, 1'b0, 4, 34, 37);
        idle(64);
        @(negedge clk);
        check("vote_datao", {23'd0, datao}, 32'd0);
        check("vote_dvalid", {31'd0, dvalid}, 32'd1);
        check("vote_flags", {29'd0, break_det, parity_err, frame_err}, 32'd0);

        // Reset mid-byte with an entry still queued
        for (int i = 0; i < 3 * 64; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
        @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 rx = 1'b1; reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_dvalid", {31'd0, dvalid}, 32'd0);
        check("rst_mid_datao", {23'd0, datao}, 32'd0);
        idle(128);

        run_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
